// File: rtl/sc_matrix_pkg.sv
// rtl/sc_matrix_pkg.sv - shared constants, command encoding and INIT frame for the matrix frame buffer
//   Contents: default matrix side, back-buffer command encoding (higher value wins),
//   per-row INIT pattern and a helper that packs it into an N*N frame vector.
package sc_matrix_pkg;

    localparam int N_DEFAULT = 8;
    localparam int N_MAX     = 16;

    // Command priority is the enum value: clear > shift > write > none.
    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_SHIFT = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    function automatic cmd_e encode_cmd(input logic clear, input logic shift, input logic write);
        if (clear) return CMD_CLEAR;
        if (shift) return CMD_SHIFT;
        if (write) return CMD_WRITE;
        return CMD_NONE;
    endfunction

    // Power-on picture for the eight-row display; rows beyond 7 are blank.
    function automatic logic [N_MAX-1:0] init_row(input int r);
        case (r)
            0:       return 16'h0010;
            1:       return 16'h0000;
            2:       return 16'h0010;
            3:       return 16'h0038;
            4:       return 16'h007C;
            5:       return 16'h007C;
            6:       return 16'h0038;
            7:       return 16'h0010;
            default: return 16'h0000;
        endcase
    endfunction

    // Row r occupies bits [r*n +: n]; wider rows are truncated to n bits.
    function automatic logic [N_MAX*N_MAX-1:0] init_frame(input int n);
        logic [N_MAX*N_MAX-1:0] f;
        logic [N_MAX-1:0]       row;
        f = '0;
        for (int r = 0; r < n; r++) begin
            row = init_row(r);
            for (int c = 0; c < n; c++) begin
                f[r*n + c] = row[c];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/sc_matrix_bank.sv
// rtl/sc_matrix_bank.sv - one N x N register bank with write, clear and scroll commands
//   clk, rst_n     : clock, asynchronous active-low reset (loads RESET_VAL)
//   cmd            : already-prioritised command for this cycle
//   wr_row/wr_data : target row and data for write; wr_data is also the row inserted by a shift
//   rows_next      : bank contents as they will be after this edge (flat, row r at [r*N +: N])
import sc_matrix_pkg::*;

module sc_matrix_bank #(
    parameter int              N         = N_DEFAULT,
    parameter int              ADDR_W    = $clog2(N),
    parameter logic [N*N-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  cmd_e              cmd,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [N-1:0]      wr_data,
    output logic [N*N-1:0]    rows_next
);

    logic [N*N-1:0] rows;
    logic           row_ok;

    // Only non-power-of-two sizes can address past the last row.
    generate
        if (N == (1 << ADDR_W)) begin : g_full
            assign row_ok = 1'b1;
        end else begin : g_partial
            assign row_ok = (32'(wr_row) < N);
        end
    endgenerate

    always_comb begin
        rows_next = rows;
        case (cmd)
            CMD_CLEAR: rows_next = '0;
            // Scroll down: row r takes row r-1, row N-1 falls off, wr_data enters row 0.
            CMD_SHIFT: rows_next = {rows[(N-1)*N-1:0], wr_data};
            CMD_WRITE: if (row_ok) rows_next[wr_row*N +: N] = wr_data;
            default:   rows_next = rows;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows <= RESET_VAL;
        end else begin
            rows <= rows_next;
        end
    end

endmodule

// File: rtl/sc_matrix_framebuf.sv
// rtl/sc_matrix_framebuf.sv - double-buffered N x N display frame buffer with frame-boundary swap
//   SC_MATRIX_FRAMEBUF_CLOCK_50     : system clock
//   SC_MATRIX_FRAMEBUF_RESET_InLow  : asynchronous active-low reset
//   wr_en/wr_row/wr_data            : write one back-buffer row (wr_data also feeds shift)
//   shift_en, clear_en              : scroll or zero the back buffer (clear > shift > write)
//   swap_req/swap_pending/swap_ack  : front/back exchange request, latched state, done pulse
//   frame_sync                      : pulse after each rd_addr N-1 -> 0 transition
//   rd_addr/rd_data                 : display read port, one cycle latency
//   Build option SC_MATRIX_FRAMEBUF_TRANSPOSE_EN: rd_data returns column rd_addr (row 0 at MSB)
//   instead of row rd_addr.
import sc_matrix_pkg::*;

module sc_matrix_framebuf #(
    parameter int N      = N_DEFAULT,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              SC_MATRIX_FRAMEBUF_CLOCK_50,
    input  logic              SC_MATRIX_FRAMEBUF_RESET_InLow,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [N-1:0]      wr_data,
    input  logic              shift_en,
    input  logic              clear_en,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_ack,
    output logic              frame_sync,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [N-1:0]      rd_data
);

    localparam logic [N_MAX*N_MAX-1:0] INIT_FULL = init_frame(N);
    localparam logic [N*N-1:0]         INIT      = INIT_FULL[N*N-1:0];

    logic              front_sel;
    logic              front_sel_next;
    logic [ADDR_W-1:0] prev_addr;
    logic              boundary;
    logic              do_swap;
    logic              addr_ok;
    cmd_e              cmd;
    cmd_e              cmd_a;
    cmd_e              cmd_b;
    logic [N*N-1:0]    rows_a_next;
    logic [N*N-1:0]    rows_b_next;
    logic [N*N-1:0]    front_rows;
    logic [N-1:0]      rd_view;

    assign boundary       = (prev_addr == ADDR_W'(N-1)) && (rd_addr == '0);
    assign do_swap        = boundary && (swap_pending || swap_req);
    assign front_sel_next = front_sel ^ do_swap;

    // Commands always target the bank that is back before this edge.
    assign cmd   = encode_cmd(clear_en, shift_en, wr_en);
    assign cmd_a = front_sel ? cmd : CMD_NONE;
    assign cmd_b = front_sel ? CMD_NONE : cmd;

    sc_matrix_bank #(.N(N), .ADDR_W(ADDR_W), .RESET_VAL(INIT)) u_bank_a (
        .clk       (SC_MATRIX_FRAMEBUF_CLOCK_50),
        .rst_n     (SC_MATRIX_FRAMEBUF_RESET_InLow),
        .cmd       (cmd_a),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rows_next (rows_a_next)
    );

    sc_matrix_bank #(.N(N), .ADDR_W(ADDR_W), .RESET_VAL('0)) u_bank_b (
        .clk       (SC_MATRIX_FRAMEBUF_CLOCK_50),
        .rst_n     (SC_MATRIX_FRAMEBUF_RESET_InLow),
        .cmd       (cmd_b),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rows_next (rows_b_next)
    );

    // Reading the post-edge contents of the post-swap front bank makes a command
    // issued in the swap cycle show up already in row 0 of the new frame. The
    // front bank never receives commands otherwise, so this equals its stored value.
    assign front_rows = front_sel_next ? rows_b_next : rows_a_next;

    generate
        if (N == (1 << ADDR_W)) begin : g_full
            assign addr_ok = 1'b1;
        end else begin : g_partial
            assign addr_ok = (32'(rd_addr) < N);
        end
    endgenerate

    always_comb begin
        rd_view = '0;
`ifdef SC_MATRIX_FRAMEBUF_TRANSPOSE_EN
        for (int r = 0; r < N; r++) begin
            rd_view[N-1-r] = front_rows[r*N + (N-1-int'(rd_addr))];
        end
`else
        rd_view = front_rows[rd_addr*N +: N];
`endif
        if (!addr_ok) begin
            rd_view = '0;
        end
    end

    always_ff @(posedge SC_MATRIX_FRAMEBUF_CLOCK_50 or negedge SC_MATRIX_FRAMEBUF_RESET_InLow) begin
        if (!SC_MATRIX_FRAMEBUF_RESET_InLow) begin
            front_sel    <= 1'b0;
            prev_addr    <= '0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
            frame_sync   <= 1'b0;
            rd_data      <= '0;
        end else begin
            front_sel    <= front_sel_next;
            prev_addr    <= rd_addr;
            swap_pending <= do_swap ? 1'b0 : (swap_pending || swap_req);
            swap_ack     <= do_swap;
            frame_sync   <= boundary;
            rd_data      <= rd_view;
        end
    end

endmodule

// File: tb/tb_sc_matrix_framebuf.sv
// tb/tb_sc_matrix_framebuf.sv - self-checking bench for sc_matrix_framebuf (N=8)
module tb_sc_matrix_framebuf;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [AW-1:0] wr_row   = '0;
    logic [N-1:0]  wr_data  = '0;
    logic          shift_en = 1'b0;
    logic          clear_en = 1'b0;
    logic          swap_req = 1'b0;
    logic [AW-1:0] rd_addr  = '0;
    logic          swap_pending;
    logic          swap_ack;
    logic          frame_sync;
    logic [N-1:0]  rd_data;

    always #5 clk = ~clk;

    sc_matrix_framebuf #(.N(N)) dut (
        .SC_MATRIX_FRAMEBUF_CLOCK_50    (clk),
        .SC_MATRIX_FRAMEBUF_RESET_InLow (rst_n),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .shift_en     (shift_en),
        .clear_en     (clear_en),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_ack     (swap_ack),
        .frame_sync   (frame_sync),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;

    // Reference: two banks as row arrays, index of the front bank, last address seen.
    logic [N-1:0] mb [2][N];
    int           mfs;
    int           mprev;
    bit           mpend;
    logic [N-1:0] exp_rd;
    bit           exp_ack;
    bit           exp_sync;

    function automatic logic [N-1:0] view(input int bank, input int k);
        logic [N-1:0] v;
        logic [N-1:0] row;
        v = '0;
`ifdef SC_MATRIX_FRAMEBUF_TRANSPOSE_EN
        for (int r = 0; r < N; r++) begin
            row = mb[bank][r];
            v[N-1-r] = row[N-1-k];
        end
`else
        row = mb[bank][k];
        v = row;
`endif
        return v;
    endfunction

    task automatic model_reset();
        logic [N-1:0] init_rows [N];
        init_rows = '{8'h10, 8'h00, 8'h10, 8'h38, 8'h7C, 8'h7C, 8'h38, 8'h10};
        for (int r = 0; r < N; r++) begin
            mb[0][r] = init_rows[r];
            mb[1][r] = '0;
        end
        mfs = 0; mprev = 0; mpend = 0;
        exp_rd = '0; exp_ack = 0; exp_sync = 0;
    endtask

    task automatic model_step();
        bit bnd, sw;
        int back;
        bnd  = (mprev == N-1) && (int'(rd_addr) == 0);
        sw   = bnd && (mpend || swap_req);
        back = 1 - mfs;
        if (clear_en) begin
            for (int r = 0; r < N; r++) mb[back][r] = '0;
        end else if (shift_en) begin
            for (int r = N-1; r > 0; r--) mb[back][r] = mb[back][r-1];
            mb[back][0] = wr_data;
        end else if (wr_en) begin
            mb[back][wr_row] = wr_data;
        end
        if (sw) mfs = 1 - mfs;
        mpend    = sw ? 1'b0 : (mpend || swap_req);
        exp_rd   = view(mfs, int'(rd_addr));
        exp_ack  = sw;
        exp_sync = bnd;
        mprev    = int'(rd_addr);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int addr, input bit we = 0, input int row = 0,
                       input logic [N-1:0] d = '0, input bit sh = 0, input bit cl = 0,
                       input bit req = 0);
        rd_addr  = AW'(addr);
        wr_en    = we;
        wr_row   = AW'(row);
        wr_data  = d;
        shift_en = sh;
        clear_en = cl;
        swap_req = req;
        @(posedge clk);
        model_step();
        #1;
        if (swap_ack) ack_cnt++;
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        check("swap_ack", 32'(swap_ack), 32'(exp_ack));
        check("frame_sync", 32'(frame_sync), 32'(exp_sync));
        check("swap_pending", 32'(swap_pending), 32'(mpend));
    endtask

    initial begin
        int a;
        model_reset();
        #2;
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_pending", 32'(swap_pending), 32'h0);
        check("rst_ack", 32'(swap_ack), 32'h0);
        check("rst_sync", 32'(frame_sync), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // INIT frame sweep
        cyc(0);
`ifdef SC_MATRIX_FRAMEBUF_TRANSPOSE_EN
        check("init_k0", 32'(rd_data), 32'h00);
`else
        check("init_k0", 32'(rd_data), 32'h10);
`endif
        for (int k = 1; k < N; k++) cyc(k);
        check("init_no_pending", 32'(swap_pending), 32'h0);

        // Write row 3 = FF, request at addr 4, swap at 7->0
        cyc(0);
        cyc(1, 1, 3, 8'hFF);
        cyc(2); cyc(3);
        cyc(4, 0, 0, '0, 0, 0, 1);
        cyc(5); cyc(6); cyc(7);
        check("pending_before_bnd", 32'(swap_pending), 32'h1);
        cyc(0);
        check("ack_at_bnd", 32'(swap_ack), 32'h1);
        for (int k = 1; k < N; k++) begin
            cyc(k);
`ifdef SC_MATRIX_FRAMEBUF_TRANSPOSE_EN
            check("row3_lit_col", 32'(rd_data & 8'h10), 32'h10);
`else
            if (k == 3) check("row3_lit", 32'(rd_data), 32'hFF);
`endif
        end

        // Request held three cycles: exactly one swap
        ack_cnt = 0;
        cyc(0);
        for (int k = 1; k < N; k++) cyc(k, 0, 0, '0, 0, 0, (k <= 3));
        cyc(0);
        for (int k = 1; k < N; k++) cyc(k);
        cyc(0);
        check("held_req_one_ack", 32'(ack_cnt), 32'd1);

        // Clear + shift + write together: clear wins
        cyc(1, 1, 2, 8'hAA, 1, 1, 1);
        for (int k = 2; k < N; k++) cyc(k);
        cyc(0);
        check("clr_row0", 32'(rd_data), 32'h0);
        for (int k = 1; k < N; k++) begin
            cyc(k);
            check("clr_rows", 32'(rd_data), 32'h0);
        end

        // Nine shifts with 1..9; first value scrolls out
        for (int i = 0; i < 9; i++) begin
            cyc((i + 1) % N, 0, 0, N'(i + 1), 1, 0, (i == 8));
        end
        for (int k = 2; k < N; k++) cyc(k);
        cyc(0);
`ifndef SC_MATRIX_FRAMEBUF_TRANSPOSE_EN
        check("shift_row0", 32'(rd_data), 32'h09);
`endif
        for (int k = 1; k < N; k++) begin
            cyc(k);
`ifndef SC_MATRIX_FRAMEBUF_TRANSPOSE_EN
            if (k == N-1) check("shift_row7", 32'(rd_data), 32'h02);
`endif
        end

        // Reset mid-frame with a swap pending
        cyc(0); cyc(1); cyc(2, 0, 0, '0, 0, 0, 1); cyc(3);
        check("pre_rst_pending", 32'(swap_pending), 32'h1);
        rst_n = 1'b0;
        #2;
        check("async_rd_data", 32'(rd_data), 32'h0);
        check("async_pending", 32'(swap_pending), 32'h0);
        check("async_ack", 32'(swap_ack), 32'h0);
        check("async_sync", 32'(frame_sync), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        ack_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) cyc(k);
        end
        cyc(0);
        check("no_ack_after_rst", 32'(ack_cnt), 32'd0);

        // Randomised traffic against the model
        a = 0;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            a = (r == 0) ? int'($urandom_range(0, N-1)) : (a + 1) % N;
            cyc(a,
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, N-1)), N'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_matrix_framebuf.md
# sc_matrix_framebuf

Double-buffered, parametrised N×N frame buffer sitting between game logic and the MAX7219 matrix controller. Game logic writes, clears or scrolls a back buffer while the controller reads the front buffer row-address by row-address. A swap request is honoured only at a frame boundary, so the display never shows a half-updated frame. It replaces the fixed eight-row pattern and hard-wired column mux in the system top.

## Interface
Parameters:
- N, 8, matrix side in pixels (rows = columns = data width); legal 2..16.
- ADDR_W, $clog2(N), row/column address width (derived; do not override).

Ports:
- SC_MATRIX_FRAMEBUF_CLOCK_50  in  1  system clock. One clock; reset is asynchronous and active-low.
- SC_MATRIX_FRAMEBUF_RESET_InLow  in  1  asynchronous active-low reset.
- wr_en  in  1  write wr_data into back-buffer row wr_row.
- wr_row  in  ADDR_W  back-buffer row index.
- wr_data  in  N  row data; bit N-1 is the leftmost pixel. Also the inserted row for shift.
- shift_en  in  1  scroll back buffer down one row; wr_data enters row 0 and row N-1 is dropped.
- clear_en  in  1  zero the whole back buffer in one cycle.
- swap_req  in  1  request front/back exchange at the next frame boundary.
- swap_pending  out  1  a request is latched and not yet executed.
- swap_ack  out  1  one-cycle pulse in the cycle after a swap executes.
- frame_sync  out  1  one-cycle pulse in the cycle after each frame boundary.
- rd_addr  in  ADDR_W  display address from the matrix controller.
- rd_data  out  N  registered display data for rd_addr.

## Operation
- Two banks, A and B, of N rows × N bits each. front_sel=0 makes A the front bank. There is no copy on swap: the old front becomes the back bank with its contents intact.
- Back-buffer command priority per cycle: clear_en > shift_en > wr_en. Lower-priority commands in the same cycle are dropped.
- Frame boundary: the registered previous rd_addr equals N-1 and the current rd_addr equals 0. No other transition counts, including 0->0 and skips to 0.
- swap_pending is set on swap_req and cleared when the swap executes. swap_req while pending has no extra effect.
- The swap executes in a boundary cycle when swap_pending or swap_req is high. front_sel toggles at the end of that cycle.
- A back-buffer command in the swap cycle goes to the pre-swap back bank, which becomes front. The command is therefore visible from the new frame's row 0.
- rd_data registers, at each edge, the front-bank content for rd_addr. In the swap cycle it uses the post-swap front_sel, so the whole new frame comes from one bank.
- Reset state:
  - front bank A holds the package INIT pattern; bank B is zero.
  - front_sel=0; rd_data=0; swap_pending=0; swap_ack=0; frame_sync=0.
  - previous-address register is 0.
- Reset mid-frame or with a swap pending discards the pending swap and any partial state. There is no partial clear or shift.
- rd_addr ≥ N (non-power-of-two N) returns rd_data=0.
- wr_row ≥ N: the write is ignored.

## Timing
- Read latency is 1 cycle: rd_addr at cycle t gives rd_data at t+1.
- Write, clear and shift take effect at the edge ending cycle t. They are visible to the display only after a swap.
- Swap at boundary cycle t: front_sel changes at the edge ending t, and swap_ack and frame_sync are high during t+1.
- Worst-case swap latency from swap_req is one full frame (N controller addresses).

## Configuration
- SC_MATRIX_FRAMEBUF_TRANSPOSE_EN defined: rd_data is the column view expected by the MAX7219 wiring.
  - For address k, rd_data bit (N-1-r) = front row r, bit (N-1-k), for r = 0..N-1.
  - Row 0 of the frame maps to the MSB of rd_data.
- Not defined: rd_data = front row rd_addr, passed straight through.
- Latency and all other behaviour are identical in both builds.

## Structure
- Package sc_matrix_pkg holds:
  - default N;
  - the INIT pattern constant per row (rows 7..0: 10h, 38h, 7Ch, 7Ch, 38h, 10h, 00h, 10h for N=8; zero-extended or truncated for other N);
  - a localparam encoding of command priority.
- Sub-module sc_matrix_bank: one N×N register bank with write, clear and shift ports, plus a reset-value parameter. It is instantiated twice. The top holds swap control, boundary detection and the read/transpose mux.

## Test plan
- Reset with N=8, TRANSPOSE on, sweep rd_addr 0..7: rd_data for k=0 is 00h, matching the INIT pattern transposed (row 0 → MSB). swap_pending=0.
- Write row 3=FFh to back buffer, assert swap_req at rd_addr=4: swap_pending=1 until rd_addr 7→0, then swap_ack pulses. The new frame shows row 3 lit starting with row 0 of that frame.
- swap_req held for 3 cycles, then released: exactly one swap and one swap_ack at the next boundary.
- Same cycle clear_en=1, shift_en=1, wr_en=1: back buffer is all zero after the swap; shift and write are dropped.
- Shift 9 times with wr_data=01h, 02h, …: after the swap, row 0 holds the last value, row 7 holds the 2nd value, and the 1st value is lost.
- Assert reset with swap_pending=1 mid-frame: all outputs are 0 immediately (asynchronous), the INIT frame is restored, and no swap_ack occurs after release.
